// File: rtl/updn_ctr_arbiter.sv
// updn_ctr_arbiter: round-robin arbiter/sequencer sharing one up/down counter among NREQ requesters.
// Define UPDN_CTR_ARB_TC_OP_EN to make op 11 count-to-terminal; otherwise op 11 is HOLD.
module updn_ctr_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int STEPW = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      req_op,
    input  logic [WIDTH*NREQ-1:0]  req_data,
    input  logic [STEPW*NREQ-1:0]  req_steps,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [WIDTH-1:0]       result,
    output logic                   busy,
    output logic [WIDTH-1:0]       ctr_data,
    output logic                   ctr_up_dn,
    output logic                   ctr_load_n,
    output logic                   ctr_cen,
    input  logic [WIDTH-1:0]       ctr_count,
    input  logic                   ctr_tercnt
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] OP_LOAD = 2'b00, OP_DOWN = 2'b10, OP_TC = 2'b11;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state;

    logic [PW-1:0]    ptr, owner, win;
    logic [PW:0]      k;
    logic             any;
    logic [1:0]       op;
    logic [STEPW-1:0] rem;
    logic             step_op, tc_run, tc_fin, exec_last;

`ifdef UPDN_CTR_ARB_TC_OP_EN
    assign tc_run = (op == OP_TC) && !ctr_tercnt;
    assign tc_fin = ctr_tercnt;
`else
    logic unused_tercnt;
    assign unused_tercnt = ctr_tercnt;
    assign tc_run = 1'b0;
    assign tc_fin = 1'b1;
`endif

    // Walk downward so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        win = '0;
        any = 1'b0;
        k   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = {1'b0, ptr} + (PW+1)'(i);
            k = (k >= (PW+1)'(NREQ)) ? k - (PW+1)'(NREQ) : k;
            if (req[k[PW-1:0]]) begin
                win = k[PW-1:0];
                any = 1'b1;
            end
        end
    end

    assign gnt        = (state == IDLE && any && !reset) ? NREQ'(1) << win : '0;
    assign busy       = state != IDLE;
    assign step_op    = op[0] ^ op[1];
    assign ctr_load_n = !(state == EXEC && op == OP_LOAD);
    assign ctr_up_dn  = !(state == EXEC && op == OP_DOWN);
    assign ctr_cen    = (state == EXEC) && ((step_op && rem != '0) || tc_run);
    assign exec_last  = (op == OP_LOAD) || (step_op && rem <= STEPW'(1)) || (op == OP_TC && tc_fin);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            op       <= OP_LOAD;
            rem      <= '0;
            ctr_data <= '0;
            done     <= '0;
            result   <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: if (any) begin
                    state    <= EXEC;
                    owner    <= win;
                    op       <= req_op[2*win +: 2];
                    ctr_data <= req_data[WIDTH*win +: WIDTH];
                    rem      <= req_steps[STEPW*win +: STEPW];
                    ptr      <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                end
                EXEC: begin
                    if (rem != '0) rem <= rem - 1'b1;
                    if (exec_last) state <= DONE;
                end
                DONE: begin
                    result <= ctr_count;
                    done   <= NREQ'(1) << owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_updn_ctr_arbiter.sv
// tb_updn_ctr_arbiter: randomized and directed checks of updn_ctr_arbiter against a transaction-level model.
// A behavioural up/down counter is attached to the counter pins.
module tb_updn_ctr_arbiter;
    logic        clk = 1'b0, reset = 1'b0;
    logic [3:0]  req = '0;
    logic [7:0]  req_op = '0;
    logic [15:0] req_data = '0, req_steps = '0;
    logic [3:0]  gnt, done, result, ctr_data, ctr_count;
    logic        busy, ctr_up_dn, ctr_load_n, ctr_cen, ctr_tercnt;
    logic [3:0]  cnt = 4'h0;

    int tests = 0, fails = 0;
    int m_ptr = 0;
    logic [3:0] m_cnt = 4'h0;

    updn_ctr_arbiter #(.WIDTH(4), .NREQ(4), .STEPW(4)) dut (
        .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_data(req_data),
        .req_steps(req_steps), .gnt(gnt), .done(done), .result(result), .busy(busy),
        .ctr_data(ctr_data), .ctr_up_dn(ctr_up_dn), .ctr_load_n(ctr_load_n),
        .ctr_cen(ctr_cen), .ctr_count(ctr_count), .ctr_tercnt(ctr_tercnt)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        if (!ctr_load_n) cnt <= ctr_data;
        else if (ctr_cen) cnt <= ctr_up_dn ? cnt + 4'h1 : cnt - 4'h1;
    assign ctr_count  = cnt;
    assign ctr_tercnt = ctr_up_dn ? (cnt == 4'hF) : (cnt == 4'h0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input int i, input logic [1:0] op, input logic [3:0] data, input logic [3:0] steps);
        req_op[2*i +: 2]    = op;
        req_data[4*i +: 4]  = data;
        req_steps[4*i +: 4] = steps;
    endtask

    function automatic int pick(input logic [3:0] p);
        for (int i = 0; i < 4; i++)
            if (p[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] final_of(input logic [1:0] op, input logic [3:0] d, input logic [3:0] n, input logic [3:0] s);
        if (op == 2'b00) return d;
        if (op == 2'b01) return s + n;
        if (op == 2'b10) return s - n;
`ifdef UPDN_CTR_ARB_TC_OP_EN
        return 4'hF;
`else
        return s;
`endif
    endfunction

    function automatic int cen_of(input logic [1:0] op, input logic [3:0] n, input logic [3:0] s);
        if (op == 2'b01 || op == 2'b10) return int'(n);
`ifdef UPDN_CTR_ARB_TC_OP_EN
        if (op == 2'b11) return 15 - int'(s);
`endif
        return 0;
    endfunction

    // Called at a negedge with the DUT idle and req nonzero; returns at the negedge of the done cycle.
    task automatic serve();
        int w, cyc, cens, loads, dir_bad, gnt_bad, dur;
        logic [1:0] op;
        logic [3:0] d, n, s, exp;
        #1;
        w = pick(req);
        check("gnt", gnt, 32'(1) << w);
        op  = req_op[2*w +: 2];
        d   = req_data[4*w +: 4];
        n   = req_steps[4*w +: 4];
        s   = m_cnt;
        exp = final_of(op, d, n, s);
        dur = (op == 2'b00) ? 1 : (cen_of(op, n, s) == 0 ? 1 : cen_of(op, n, s) + (op == 2'b11 ? 1 : 0));
        m_ptr = (w + 1) % 4;
        m_cnt = exp;
        @(posedge clk);
        #1 req[w] = 1'b0;
        cyc = 0; cens = 0; loads = 0; dir_bad = 0; gnt_bad = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (done == '0) begin
                cens  += int'(ctr_cen);
                loads += int'(!ctr_load_n);
                if (gnt != '0 || !busy) gnt_bad++;
                if (ctr_cen && ctr_up_dn != (op != 2'b10)) dir_bad++;
            end
        end while (done == '0 && cyc < 40);
        check("latency", cyc, dur + 2);
        check("done", done, 32'(1) << w);
        check("result", result, exp);
        check("cen_cycles", cens, cen_of(op, n, s));
        check("load_cycles", loads, op == 2'b00 ? 1 : 0);
        check("up_dn", dir_bad, 0);
        check("busy_gnt_exec", gnt_bad, 0);
        check("idle_busy", busy, 0);
        if (op == 2'b00) check("ctr_data", ctr_data, d);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) set_cmd(i, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom_range(0, 6)));
        req = 4'b1111;
        #2 reset = 1'b1;
        #11;
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_load_n", ctr_load_n, 1);
        check("rst_cen", ctr_cen, 0);
        check("rst_up_dn", ctr_up_dn, 1);
        check("rst_data", ctr_data, 0);
        @(negedge clk) reset = 1'b0;
        while (req != '0) serve();

        set_cmd(0, 2'b00, 4'hA, 4'h0); req = 4'b0001; serve();
        check("load_result", result, 4'hA);

        set_cmd(1, 2'b00, 4'hE, 4'h0); req = 4'b0010; serve();
        set_cmd(1, 2'b01, 4'h0, 4'h3); req = 4'b0010; serve();
        check("up_wrap", result, 4'h1);

        for (int i = 0; i < 4; i++) set_cmd(i, 2'b01, 4'h0, 4'h0);
        for (int r = 0; r < 5; r++) begin req = 4'b1111; serve(); end
        req = '0;

        set_cmd(2, 2'b00, 4'hC, 4'h0); req = 4'b0100; serve();
        set_cmd(2, 2'b11, 4'h0, 4'h0); req = 4'b0100; serve();
`ifdef UPDN_CTR_ARB_TC_OP_EN
        check("tc_result", result, 4'hF);
`else
        check("hold_result", result, 4'hC);
`endif

        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < 4; i++)
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    set_cmd(i, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom_range(0, 15)));
                    req[i] = 1'b1;
                end
            if (req == '0) begin
                set_cmd(0, 2'b01, 4'h0, 4'($urandom_range(0, 15)));
                req[0] = 1'b1;
            end
            serve();
        end
        while (req != '0) serve();

        set_cmd(3, 2'b00, 4'h8, 4'h0); req = 4'b1000; serve();
        set_cmd(3, 2'b10, 4'h0, 4'h8); req = 4'b1000;
        #1 check("mid_gnt", gnt, 4'b1000);
        @(posedge clk);
        #1 req = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_cen", ctr_cen, 1);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_cen_off", ctr_cen, 0);
        check("mid_done", done, 0);
        @(negedge clk) reset = 1'b0;
        m_ptr = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("mid_no_done", done, 0);
        end
        check("mid_count", ctr_count, 4'h5);
        m_cnt = 4'h5;
        set_cmd(3, 2'b01, 4'h0, 4'h1); req = 4'b1000; serve();
        set_cmd(0, 2'b01, 4'h0, 4'h0); set_cmd(3, 2'b01, 4'h0, 4'h0); req = 4'b1001; serve();
        while (req != '0) serve();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
